vga_frame_scanner: RTL and testbench

- Downstream consumer of the VGA RAM that the equalizer processor fills with the equalized image.
- Generates 640x480@60 Hz VGA timing from the 50 MHz system clock.
- Reads the grayscale framebuffer in raster order and drives the grayscale pixel onto R=G=B, centred in the active area; black elsewhere.
- Display enable is latched only at frame boundaries, so a partially written image never tears.

---
 rtl/vga_frame_scanner.sv | 143 ++++++++++++++
 tb/tb_vga_frame_scanner.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_scanner.sv
// VGA raster scanner: generates sync timing from a clk/2 pixel tick and reads a grayscale
// framebuffer in raster order, showing it centred in the active area with R=G=B.
module vga_frame_scanner #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 256,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              vga_clk,
  output logic              hsync,
  output logic              vsync,
  output logic              blank_n,
  output logic              sync_n,
  output logic [DATA_W-1:0] red,
  output logic [DATA_W-1:0] green,
  output logic [DATA_W-1:0] blue,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] X0     = HW'((H_ACTIVE - IMG_W) / 2);
  localparam logic [HW-1:0] X1     = HW'((H_ACTIVE - IMG_W) / 2 + IMG_W);

  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] Y0     = VW'((V_ACTIVE - IMG_H) / 2);
  localparam logic [VW-1:0] Y1     = VW'((V_ACTIVE - IMG_H) / 2 + IMG_H);

  logic              pix_en_q, pix_en_d;
  logic [HW-1:0]     h_cnt_q, h_cnt_d;
  logic [VW-1:0]     v_cnt_q, v_cnt_d;
  logic              en_q, en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, addr_base;
  logic              frame_start_q, frame_start_d;
  logic              hsync_p1_q, hsync_p1_d;
  logic              vsync_p1_q, vsync_p1_d;
  logic              vld_p1_q, vld_p1_d;
  logic [DATA_W-1:0] pix_p1_q, pix_p1_d;

  logic visible, hs_act, vs_act, in_img, frame_bound;

  assign visible     = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign hs_act      = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
  assign vs_act      = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
  assign in_img      = (h_cnt_q >= X0) && (h_cnt_q < X1) && (v_cnt_q >= Y0) && (v_cnt_q < Y1);
  assign frame_bound = (h_cnt_q == '0) && (v_cnt_q == '0);

  always_comb begin
    pix_en_d      = ~pix_en_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    en_d          = en_q;
    addr_base     = mem_addr_q;
    mem_addr_d    = mem_addr_q;
    frame_start_d = 1'b0;
    hsync_p1_d    = hsync_p1_q;
    vsync_p1_d    = vsync_p1_q;
    vld_p1_d      = vld_p1_q;
    pix_p1_d      = pix_p1_q;
    if (pix_en_q) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
      end else begin
        h_cnt_d = h_cnt_q + HW'(1);
      end
      // Enable and the read address are only re-armed at the top of a frame so an image
      // being rewritten mid-frame cannot tear on screen.
      if (frame_bound) begin
        en_d          = enable;
        frame_start_d = 1'b1;
        addr_base     = '0;
      end
      mem_addr_d = in_img ? addr_base + ADDR_W'(1) : addr_base;
      // Stage p1: timing and colour for the pixel the counters just left.
      hsync_p1_d = ~hs_act;
      vsync_p1_d = ~vs_act;
      vld_p1_d   = visible;
      pix_p1_d   = (in_img && en_q) ? mem_data : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_en_q      <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      en_q          <= 1'b0;
      mem_addr_q    <= '0;
      frame_start_q <= 1'b0;
      hsync_p1_q    <= 1'b1;
      vsync_p1_q    <= 1'b1;
      vld_p1_q      <= 1'b0;
      pix_p1_q      <= '0;
    end else begin
      pix_en_q      <= pix_en_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      en_q          <= en_d;
      mem_addr_q    <= mem_addr_d;
      frame_start_q <= frame_start_d;
      hsync_p1_q    <= hsync_p1_d;
      vsync_p1_q    <= vsync_p1_d;
      vld_p1_q      <= vld_p1_d;
      pix_p1_q      <= pix_p1_d;
    end
  end

  assign vga_clk     = pix_en_q;
  assign mem_addr    = mem_addr_q;
  assign frame_start = frame_start_q;
  assign hsync       = hsync_p1_q;
  assign vsync       = vsync_p1_q;
  assign blank_n     = vld_p1_q;
  assign sync_n      = 1'b0;
  assign red         = pix_p1_q;
  assign green       = pix_p1_q;
  assign blue        = pix_p1_q;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Directed bench for vga_frame_scanner using a shrunken raster (24x16 total, 8x4 image)
// so whole frames run in a few hundred pixel ticks.
module tb_vga_frame_scanner;

  localparam int HT = 24;
  localparam int VT = 16;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] mem_data;
  logic [5:0] mem_addr;
  logic       vga_clk, hsync, vsync, blank_n, sync_n, frame_start;
  logic [7:0] red, green, blue;
  logic       mem_ff;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ticks, th, tv;

  vga_frame_scanner #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .IMG_W(8), .IMG_H(4), .ADDR_W(6), .DATA_W(8)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mem_data(mem_data), .mem_addr(mem_addr),
    .vga_clk(vga_clk), .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .sync_n(sync_n),
    .red(red), .green(green), .blue(blue), .frame_start(frame_start)
  );

  always #10 clk = ~clk;

  // Framebuffer with one clk read latency; contents are 0x40 + address unless forced to FF.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    mem_data <= mem_ff ? 8'hFF : {2'b01, mem_addr};
  end

  function automatic bit in_win(int h, int v);
    return (h >= 4) && (h < 12) && (v >= 4) && (v < 8);
  endfunction

  function automatic int exp_addr(int h, int v);
    int c;
    if (v < 4) return 0;
    if (v >= 8) return 32;
    c = h - 3;
    if (c < 0) c = 0;
    if (c > 8) c = 8;
    return (v - 4) * 8 + c;
  endfunction

  task automatic next_tick();
    repeat (2) @(posedge clk);
    #1;
    ticks = ticks + 1;
    th = ticks % HT;
    tv = (ticks / HT) % VT;
  endtask

  task automatic run_to(int h, int v);
    for (int i = 0; i < FT + 1; i++) begin
      if (th == h && tv == v) break;
      next_tick();
    end
  endtask

  task automatic release_rst();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ticks = -1;
    th = -1;
    tv = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; mem_ff = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({hsync, vsync, blank_n, frame_start, vga_clk, sync_n} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 110000", {hsync, vsync, blank_n, frame_start, vga_clk, sync_n});
    end
    checks++;
    if (mem_addr !== 6'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", mem_addr); end
    checks++;
    if ({red, green, blue} !== 24'h0) begin errors++; $display("FAIL reset_rgb: got %h expected 0", {red, green, blue}); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({frame_start, vga_clk} !== 2'b01) begin errors++; $display("FAIL rel_clk1: got %b expected 01", {frame_start, vga_clk}); end
    @(posedge clk); #1;
    ticks = 0; th = 0; tv = 0;
    checks++;
    if ({frame_start, vga_clk, hsync, vsync, blank_n} !== 5'b10111) begin
      errors++;
      $display("FAIL rel_clk2: got %b expected 10111", {frame_start, vga_clk, hsync, vsync, blank_n});
    end
    @(posedge clk); #1;
    checks++;
    if ({frame_start, vga_clk} !== 2'b01) begin errors++; $display("FAIL rel_clk3: got %b expected 01", {frame_start, vga_clk}); end
    @(posedge clk); #1;
    ticks = 1; th = 1; tv = 0;
  endtask

  task automatic test_enable_latch();
    for (int i = 0; i < FT; i++) begin
      if (th == 0 && tv == 6) enable = 1'b1;
      next_tick();
      checks++;
      if ({red, green, blue} !== 24'h0) begin
        errors++;
        $display("FAIL en_black (%0d,%0d): got %h expected 0", th, tv, {red, green, blue});
      end
      checks++;
      if (blank_n !== ((th < 16) && (tv < 12))) begin
        errors++;
        $display("FAIL en_blank (%0d,%0d): got %b", th, tv, blank_n);
      end
      if (th == HT - 1 && tv == VT - 1) break;
    end
    checks++;
    if (mem_addr !== 6'd32) begin errors++; $display("FAIL en_addr_hold: got %0d expected 32", mem_addr); end
  endtask

  task automatic test_frame_scan();
    int hs_cnt = 0, vs_cnt = 0, bl_cnt = 0, fs_cnt = 0, fs_cyc0 = 0;
    logic [7:0] e_rgb;
    logic [3:0] e_ctl;
    for (int i = 0; i <= FT; i++) begin
      next_tick();
      e_ctl = {!(th >= 18 && th < 22), !(tv >= 13 && tv < 15), (th < 16) && (tv < 12), (th == 0) && (tv == 0)};
      e_rgb = in_win(th, tv) ? 8'(8'h40 + (tv - 4) * 8 + th - 4) : 8'h00;
      checks++;
      if ({hsync, vsync, blank_n, frame_start} !== e_ctl) begin
        errors++;
        $display("FAIL scan_ctl (%0d,%0d): got %b expected %b", th, tv, {hsync, vsync, blank_n, frame_start}, e_ctl);
      end
      checks++;
      if ({red, green, blue} !== {3{e_rgb}}) begin
        errors++;
        $display("FAIL scan_rgb (%0d,%0d): got %h expected %h", th, tv, {red, green, blue}, {3{e_rgb}});
      end
      checks++;
      if (mem_addr !== 6'(exp_addr(th, tv))) begin
        errors++;
        $display("FAIL scan_addr (%0d,%0d): got %0d expected %0d", th, tv, mem_addr, exp_addr(th, tv));
      end
      if (i == 0) fs_cyc0 = cyc;
      if (i < FT) begin
        hs_cnt += int'(!hsync);
        vs_cnt += int'(!vsync);
        bl_cnt += int'(blank_n);
        fs_cnt += int'(frame_start);
      end
    end
    checks++;
    if (hs_cnt !== 64) begin errors++; $display("FAIL hsync_low_ticks: got %0d expected 64", hs_cnt); end
    checks++;
    if (vs_cnt !== 48) begin errors++; $display("FAIL vsync_low_ticks: got %0d expected 48", vs_cnt); end
    checks++;
    if (bl_cnt !== 192) begin errors++; $display("FAIL visible_ticks: got %0d expected 192", bl_cnt); end
    checks++;
    if (fs_cnt !== 1) begin errors++; $display("FAIL frame_start_count: got %0d expected 1", fs_cnt); end
    checks++;
    if (cyc - fs_cyc0 !== 2 * FT) begin errors++; $display("FAIL frame_period: got %0d expected %0d", cyc - fs_cyc0, 2 * FT); end
  endtask

  task automatic test_blanking();
    mem_ff = 1'b1;
    for (int i = 0; i < FT; i++) begin
      next_tick();
      checks++;
      if ({red, green, blue} !== (in_win(th, tv) ? 24'hFFFFFF : 24'h0)) begin
        errors++;
        $display("FAIL blank_rgb (%0d,%0d): got %h blank_n %b", th, tv, {red, green, blue}, blank_n);
      end
      if (th == HT - 1 && tv == VT - 1) break;
    end
    mem_ff = 1'b0;
  endtask

  task automatic test_reset_mid();
    run_to(7, 5);
    checks++;
    if ({red, mem_addr} !== {8'h4B, 6'd12}) begin
      errors++;
      $display("FAIL mid_pre: got red %h addr %0d expected 4b 12", red, mem_addr);
    end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({hsync, vsync, blank_n, frame_start, vga_clk} !== 5'b11000) begin
      errors++;
      $display("FAIL mid_ctl: got %b expected 11000", {hsync, vsync, blank_n, frame_start, vga_clk});
    end
    checks++;
    if ({red, green, blue, mem_addr} !== 30'h0) begin
      errors++;
      $display("FAIL mid_data: got rgb %h addr %0d expected 0", {red, green, blue}, mem_addr);
    end
    release_rst();
    next_tick();
    checks++;
    if ({frame_start, mem_addr} !== {1'b1, 6'd0}) begin
      errors++;
      $display("FAIL mid_restart: got fs %b addr %0d expected 1 0", frame_start, mem_addr);
    end
    run_to(20, 13);
    checks++;
    if ({hsync, vsync} !== 2'b00) begin errors++; $display("FAIL mid2_pre: got %b expected 00", {hsync, vsync}); end
    rst = 1'b1;
    #1;
    checks++;
    if ({hsync, vsync} !== 2'b11) begin errors++; $display("FAIL mid2_sync: got %b expected 11", {hsync, vsync}); end
    release_rst();
    run_to(4, 4);
    checks++;
    if ({red, mem_addr} !== {8'h40, 6'd1}) begin
      errors++;
      $display("FAIL mid2_first_pix: got red %h addr %0d expected 40 1", red, mem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_enable_latch();
    test_frame_scan();
    test_blanking();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
